// File: rtl/iter_block_cipher_core.sv
// ============================================================================
// Module      : iter_block_cipher_core
// Description : Iterative 128-bit round cipher (encrypt/decrypt) with a
//               valid/ready request and result handshake and UNROLL rounds
//               per clock. Optional macro: CIPHER_KEY_ZEROIZE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_block_cipher_core #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned UNROLL     = 1,
    parameter logic [7:0]  SBOX_XOR   = 8'h63
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [127:0] data_in,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0]  c_N = 4'(NUM_ROUNDS);
    localparam logic [3:0]  c_U = 4'(UNROLL);
    // Nibble p holds the source byte index for output byte p of the shift step.
    localparam logic [63:0] c_SR_MAP = 64'hFA50_B61C_72D8_3E94;

    state_t       state_q, state_d;
    logic [127:0] s_q, s_d;
    logic [127:0] key_q, key_d;
    logic         mode_q, mode_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] round_s;

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int i = 0; i < 16; i++) res[i*8 +: 8] = s[i*8 +: 8] ^ SBOX_XOR;
        return res;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int p = 0; p < 16; p++) res[p*8 +: 8] = s[int'(c_SR_MAP[p*4 +: 4])*8 +: 8];
        return res;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int p = 0; p < 16; p++) res[int'(c_SR_MAP[p*4 +: 4])*8 +: 8] = s[p*8 +: 8];
        return res;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            if (inv) res[c*32 +: 32] = {s[c*32 +: 8], s[c*32+8 +: 24]};
            else     res[c*32 +: 32] = {s[c*32 +: 24], s[c*32+24 +: 8]};
        end
        return res;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] k, input logic [3:0] r);
        return k ^ {4{28'd0, r}};
    endfunction

    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [3:0] r,
                                               input logic [127:0] k);
        logic [127:0] t;
        t = shift_rows(sub_bytes(s));
        if (r != c_N) t = mix_cols(t, 1'b0);
        return t ^ round_key(k, r);
    endfunction

    // Round 1 of decrypt also removes the initial key whitening.
    function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [3:0] r,
                                               input logic [127:0] k);
        logic [127:0] t;
        t = s ^ round_key(k, r);
        if (r != c_N) t = mix_cols(t, 1'b1);
        t = sub_bytes(inv_shift_rows(t));
        if (r == 4'd1) t = t ^ k;
        return t;
    endfunction

    always_comb begin
        round_s = s_q;
        for (int u = 0; u < int'(UNROLL); u++) begin
            if (mode_q) round_s = dec_round(round_s, c_N - cnt_q - 4'(u), key_q);
            else        round_s = enc_round(round_s, cnt_q + 4'(u) + 4'd1, key_q);
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        key_d   = key_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    key_d   = key;
                    mode_d  = mode;
                    s_d     = mode ? data_in : (data_in ^ key);
                    cnt_d   = 4'd0;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                s_d   = round_s;
                cnt_d = cnt_q + c_U;
                if ((cnt_q + c_U) == c_N) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
`ifdef CIPHER_KEY_ZEROIZE_EN
                    key_d   = '0;
                    s_d     = '0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            key_q   <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
`ifdef CIPHER_KEY_ZEROIZE_EN
    assign data_out  = out_valid ? s_q : '0;
`else
    assign data_out  = s_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_iter_block_cipher_core.sv
// ============================================================================
// Module      : tb_iter_block_cipher_core
// Description : Directed bench for iter_block_cipher_core (default, UNROLL=2
//               and NUM_ROUNDS=1 instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iter_block_cipher_core;

    localparam logic [127:0] c_PT   = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] c_KEY  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] c_PT2  = 128'hdeadbeef_01234567_89abcdef_f00dcafe;
    localparam logic [127:0] c_KEY2 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] c_PT3  = 128'h3243f6a8_885a308d_313198a2_e0370734;
    localparam logic [127:0] c_KEY3 = 128'hffffffff_00000000_a5a5a5a5_5a5a5a5a;

    logic         clk;
    logic         rst;
    logic         iv   [3];
    logic         ir   [3];
    logic         mo   [3];
    logic [127:0] di   [3];
    logic [127:0] ky   [3];
    logic         ov   [3];
    logic         ordy [3];
    logic [127:0] dout [3];
    logic         bsy  [3];

    int n_vec;
    int n_err;

    iter_block_cipher_core u_dut (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .mode(mo[0]),
        .data_in(di[0]), .key(ky[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .data_out(dout[0]), .busy(bsy[0])
    );

    iter_block_cipher_core #(.UNROLL(2)) u_dut_u2 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .mode(mo[1]),
        .data_in(di[1]), .key(ky[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .data_out(dout[1]), .busy(bsy[1])
    );

    iter_block_cipher_core #(.NUM_ROUNDS(1)) u_dut_n1 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .mode(mo[2]),
        .data_in(di[2]), .key(ky[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .data_out(dout[2]), .busy(bsy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference encryption built byte-by-byte from the cipher definition.
    function automatic logic [127:0] enc_model(input logic [127:0] pt, input logic [127:0] k,
                                               input int n);
        logic [7:0]   b [16];
        logic [127:0] s;
        s = pt ^ k;
        for (int r = 1; r <= n; r++) begin
            for (int i = 0; i < 16; i++) b[i] = s[i*8 +: 8] ^ 8'h63;
            s = {b[15], b[10], b[5], b[0], b[11], b[6], b[1], b[12],
                 b[7],  b[2],  b[13], b[8], b[3], b[14], b[9], b[4]};
            if (r < n)
                for (int c = 0; c < 4; c++) s[c*32 +: 32] = {s[c*32 +: 24], s[c*32+24 +: 8]};
            s = s ^ k ^ {4{32'(r)}};
        end
        return s;
    endfunction

    // Called #1 after an accept edge; counts edges until out_valid rises.
    task automatic wait_valid(input int idx, input int exp_lat, input string tag);
        int lat;
        lat = 0;
        while (!ov[idx] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    endtask

    task automatic run_req(input int idx, input logic md, input logic [127:0] din,
                           input logic [127:0] k, input int exp_lat,
                           input logic [127:0] exp, input string tag,
                           output logic [127:0] res);
        mo[idx] = md; di[idx] = din; ky[idx] = k; iv[idx] = 1'b1; ordy[idx] = 1'b1;
        check_eq({tag, "_in_ready"}, 128'(ir[idx]), 128'(1));
        @(posedge clk); #1;
        // Scramble the inputs: the core must work from its captured copies.
        iv[idx] = 1'b0; mo[idx] = ~md; di[idx] = ~din; ky[idx] = din ^ k;
        wait_valid(idx, exp_lat, tag);
        res = dout[idx];
        check_eq({tag, "_data"}, dout[idx], exp);
        @(posedge clk); #1;
        check_eq({tag, "_ov_clr"}, 128'(ov[idx]), 128'(0));
`ifdef CIPHER_KEY_ZEROIZE_EN
        check_eq({tag, "_post_dout"}, dout[idx], 128'd0);
`else
        check_eq({tag, "_post_dout"}, dout[idx], res);
`endif
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] ct;
        logic [127:0] held;
        int           ov_seen;

        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; mo[i] = 1'b0; di[i] = '0; ky[i] = '0; ordy[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rst%0d_ov", i),   128'(ov[i]),  128'(0));
            check_eq($sformatf("rst%0d_dout", i), dout[i],      128'd0);
            check_eq($sformatf("rst%0d_busy", i), 128'(bsy[i]), 128'(0));
            check_eq($sformatf("rst%0d_rdy", i),  128'(ir[i]),  128'(1));
        end
        @(posedge clk); #1;

        run_req(2, 1'b0, 128'd0, 128'd0, 1,
                128'h63636362_63636362_63636362_63636362, "n1_enc", res);
        run_req(2, 1'b1, res, 128'd0, 1, 128'd0, "n1_dec", res);

        run_req(0, 1'b0, c_PT, c_KEY, 10, enc_model(c_PT, c_KEY, 10), "def_enc", ct);
        run_req(0, 1'b1, ct, c_KEY, 10, c_PT, "def_dec", res);
        run_req(1, 1'b0, c_PT, c_KEY, 5, enc_model(c_PT, c_KEY, 10), "u2_enc", ct);
        run_req(1, 1'b1, ct, c_KEY, 5, c_PT, "u2_dec", res);
        run_req(0, 1'b0, c_PT2, c_KEY2, 10, enc_model(c_PT2, c_KEY2, 10), "def_enc2", ct);
        run_req(1, 1'b1, ct, c_KEY2, 5, c_PT2, "u2_dec2", res);

        // Backpressure with a new request pending while the result is held.
        ordy[0] = 1'b0; mo[0] = 1'b0; di[0] = c_PT2; ky[0] = c_KEY2; iv[0] = 1'b1;
        @(posedge clk); #1;
        di[0] = c_PT3; ky[0] = c_KEY3;
        wait_valid(0, 10, "bp");
        held = dout[0];
        check_eq("bp_data", held, enc_model(c_PT2, c_KEY2, 10));
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            check_eq($sformatf("bp_ov_%0d", c),   128'(ov[0]), 128'(1));
            check_eq($sformatf("bp_dout_%0d", c), dout[0],     held);
            check_eq($sformatf("bp_rdy_%0d", c),  128'(ir[0]), 128'(0));
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_rel_ov",   128'(ov[0]),  128'(0));
        check_eq("bp_rel_rdy",  128'(ir[0]),  128'(1));
        check_eq("bp_rel_busy", 128'(bsy[0]), 128'(0));
        @(posedge clk); #1;
        iv[0] = 1'b0;
        check_eq("bp_next_busy", 128'(bsy[0]), 128'(1));
        wait_valid(0, 10, "bp_next");
        check_eq("bp_next_data", dout[0], enc_model(c_PT3, c_KEY3, 10));
        @(posedge clk); #1;

        // Asynchronous reset in the middle of round 4.
        mo[0] = 1'b0; di[0] = c_PT3; ky[0] = c_KEY3; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("mrst_ov",   128'(ov[0]),  128'(0));
        check_eq("mrst_dout", dout[0],      128'd0);
        check_eq("mrst_busy", 128'(bsy[0]), 128'(0));
        check_eq("mrst_rdy",  128'(ir[0]),  128'(1));
        @(posedge clk); #1 rst = 1'b0;
        ov_seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (ov[0]) ov_seen++;
        end
        check_eq("mrst_no_result", 128'(ov_seen), 128'(0));
        run_req(0, 1'b0, c_PT3, c_KEY3, 10, enc_model(c_PT3, c_KEY3, 10), "mrst_fresh", res);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
